// File: rtl/noc_vc_loopback.sv
// noc_vc_loopback: per-VC flit FIFOs looped back through a packet-atomic round-robin output arbiter.
// Optional macro OPTIMSOC_NOC_LOOPBACK_SWAP_EN exchanges dest/src fields of header and single flits.
module noc_vc_loopback #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int VCHANNELS       = 3,
  parameter int DEPTH           = 4,
  localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_sys_n,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]  in_valid,
  output logic [VCHANNELS-1:0]  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [VCHANNELS-1:0]  out_valid,
  input  logic [VCHANNELS-1:0]  out_ready,
  output logic                  idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
  localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_LAST   = FLIT_TYPE_WIDTH'(2'b10);
  localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_SINGLE = FLIT_TYPE_WIDTH'(2'b11);
  localparam logic [GW-1:0] LAST_GRANT_RST = GW'(VCHANNELS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  logic [FLIT_WIDTH-1:0]      r_mem [VCHANNELS][DEPTH];
  logic [AW-1:0]              r_wr_ptr [VCHANNELS];
  logic [AW-1:0]              r_rd_ptr [VCHANNELS];
  logic [CW-1:0]              r_count [VCHANNELS];
  logic [VCHANNELS-1:0]       w_full, w_empty, w_push, w_pop;
  logic [VCHANNELS-1:0]       w_lowest, w_in_ready, w_out_valid;
  logic                       w_multi;
  state_t                     r_state, w_state_nxt;
  logic [GW-1:0]              r_grant, w_grant_nxt, r_last_grant, w_last_nxt;
  logic [GW-1:0]              w_rr_pick, w_rr_idx;
  logic                       w_rr_found;
  logic [FLIT_WIDTH-1:0]      w_head, w_head_x;
  logic [FLIT_TYPE_WIDTH-1:0] w_head_type;
  logic                       w_head_tail;

  // FIFO fill status per VC
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    for (int v = 0; v < VCHANNELS; v++) begin
      w_full[v]  = (r_count[v] == CW'(DEPTH));
      w_empty[v] = (r_count[v] == '0);
    end
  end

  // Input acceptance: with several requesters only the lowest index may enter
  always_comb begin
    w_multi  = |(in_valid & (in_valid - VCHANNELS'(1'b1)));
    w_lowest = in_valid & (~in_valid + VCHANNELS'(1'b1));
    if (w_multi) begin
      w_in_ready = w_lowest & ~w_full;
    end else begin
      w_in_ready = ~w_full;
    end
    w_push = in_valid & w_in_ready;
  end

  assign w_head      = r_mem[r_grant][r_rd_ptr[r_grant]];
  assign w_head_type = w_head[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
  assign w_head_tail = (w_head_type == TYPE_LAST) || (w_head_type == TYPE_SINGLE);
  assign w_out_valid = ((r_state == ST_BUSY) && !w_empty[r_grant]) ?
                       (VCHANNELS'(1'b1) << r_grant) : '0;
  assign w_pop       = w_out_valid & out_ready;

`ifdef OPTIMSOC_NOC_LOOPBACK_SWAP_EN
  localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HEADER = FLIT_TYPE_WIDTH'(2'b01);

  if (FLIT_DATA_WIDTH < 32) begin : g_width_check
    $error("noc_vc_loopback: address swap needs FLIT_DATA_WIDTH >= 32");
  end

  function automatic logic [FLIT_WIDTH-1:0] swap_addr(input logic [FLIT_WIDTH-1:0] f);
    logic [FLIT_WIDTH-1:0] s;
    s        = f;
    s[31:27] = f[23:19];
    s[23:19] = f[31:27];
    return s;
  endfunction

  assign w_head_x = ((w_head_type == TYPE_HEADER) || (w_head_type == TYPE_SINGLE)) ?
                    swap_addr(w_head) : w_head;
`else
  assign w_head_x = w_head;
`endif

  assign out_valid = w_out_valid;
  assign out_flit  = (|w_out_valid) ? w_head_x : '0;
  assign in_ready  = w_in_ready;
  assign idle      = (r_state == ST_IDLE) && (&w_empty);

  // Round-robin search: first non-empty VC after the last served one
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = '0;
    w_rr_idx   = '0;
    for (int i = 1; i <= VCHANNELS; i++) begin
      w_rr_idx = GW'((int'(r_last_grant) + i) % VCHANNELS);
      if (!w_rr_found && !w_empty[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_rr_idx;
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Arbiter next state: a grant is held until the tail flit of its packet leaves
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_rr_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_pop[r_grant] && w_head_tail) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_GRANT_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // FIFO pointers and fill counters
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int v = 0; v < VCHANNELS; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VCHANNELS; v++) begin
        if (w_push[v]) begin
          r_wr_ptr[v] <= r_wr_ptr[v] + AW'(1'b1);
        end
        if (w_pop[v]) begin
          r_rd_ptr[v] <= r_rd_ptr[v] + AW'(1'b1);
        end
        case ({w_push[v], w_pop[v]})
          2'b10:   r_count[v] <= r_count[v] + CW'(1'b1);
          2'b01:   r_count[v] <= r_count[v] - CW'(1'b1);
          default: r_count[v] <= r_count[v];
        endcase
      end
    end
  end

  // FIFO storage; contents are don't-care while the counter says empty
  always_ff @(posedge clk) begin
    for (int v = 0; v < VCHANNELS; v++) begin
      if (w_push[v]) begin
        r_mem[v][r_wr_ptr[v]] <= in_flit;
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_loopback.sv
// Self-checking bench for noc_vc_loopback: directed scenarios plus a randomized run
// against a queue-level reference model.
module tb_noc_vc_loopback;

  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int NVC   = 3;
  localparam int DEPTH = 4;
  localparam int FW    = DW + TW;

  logic           clk = 1'b0;
  logic           rst_sys_n;
  logic [FW-1:0]  in_flit;
  logic [NVC-1:0] in_valid;
  logic [NVC-1:0] in_ready;
  logic [FW-1:0]  out_flit;
  logic [NVC-1:0] out_valid;
  logic [NVC-1:0] out_ready;
  logic           idle;

  int tb_tests = 0;
  int tb_fails = 0;

  logic [FW-1:0]  tb_pend [NVC][$];
  int             obs_vc[$];
  logic [FW-1:0]  obs_flit[$];
  logic [NVC-1:0] last_in_ready;
  logic [NVC-1:0] last_out_valid;
  logic [FW-1:0]  last_out_flit;

  always #5 clk = ~clk;

  noc_vc_loopback #(
    .FLIT_DATA_WIDTH(DW),
    .FLIT_TYPE_WIDTH(TW),
    .VCHANNELS(NVC),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_sys_n(rst_sys_n),
    .in_flit(in_flit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_flit(out_flit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .idle(idle)
  );

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  // Expected appearance of a flit at the output
  function automatic logic [FW-1:0] xform(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r = f;
`ifdef OPTIMSOC_NOC_LOOPBACK_SWAP_EN
    if (f[FW-1 -: 2] == 2'b01 || f[FW-1 -: 2] == 2'b11) begin
      r[31:27] = f[23:19];
      r[23:19] = f[31:27];
    end
`endif
    return r;
  endfunction

  task automatic clear_logs();
    for (int k = 0; k < NVC; k++) tb_pend[k].delete();
    obs_vc.delete();
    obs_flit.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_sys_n = 1'b0;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_sys_n = 1'b1;
  endtask

  // Drive pending flits (lowest VC owns in_flit) and log every output handshake
  task automatic run_cycles(input int n, input logic [NVC-1:0] rdy);
    int lo;
    logic [NVC-1:0] v;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      out_ready = rdy;
      v  = '0;
      lo = -1;
      for (int k = NVC - 1; k >= 0; k--) begin
        if (tb_pend[k].size() > 0) begin
          v[k] = 1'b1;
          lo   = k;
        end
      end
      in_valid = v;
      in_flit  = (lo >= 0) ? tb_pend[lo][0] : '0;
      #1;
      last_in_ready  = in_ready;
      last_out_valid = out_valid;
      last_out_flit  = out_flit;
      for (int k = 0; k < NVC; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          obs_vc.push_back(k);
          obs_flit.push_back(out_flit);
        end
      end
      if (lo >= 0 && in_ready[lo]) void'(tb_pend[lo].pop_front());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_sys_n = 1'b0;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '1;
    #1;
    tb_tests++; if (out_valid !== 3'b000) begin tb_fails++; $display("FAIL reset_out_valid: got %b expected %b", out_valid, 3'b000); end
    tb_tests++; if (out_flit !== 34'h0) begin tb_fails++; $display("FAIL reset_out_flit: got %h expected 0", out_flit); end
    tb_tests++; if (in_ready !== 3'b111) begin tb_fails++; $display("FAIL reset_in_ready: got %b expected 111", in_ready); end
    tb_tests++; if (idle !== 1'b1) begin tb_fails++; $display("FAIL reset_idle: got %b expected 1", idle); end
    @(negedge clk);
    rst_sys_n = 1'b1;
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] f;
    do_reset();
    f = mk(2'b11, 32'h0000_0005);
    @(negedge clk);
    out_ready = 3'b111; in_valid = 3'b010; in_flit = f;
    #1;
    tb_tests++; if (in_ready !== 3'b111) begin tb_fails++; $display("FAIL single_in_ready: got %b expected 111", in_ready); end
    @(negedge clk);
    in_valid = '0; in_flit = '0;
    #1;
    tb_tests++; if (out_valid !== 3'b000) begin tb_fails++; $display("FAIL single_early_valid: got %b expected 000", out_valid); end
    tb_tests++; if (idle !== 1'b0) begin tb_fails++; $display("FAIL single_busy_idle: got %b expected 0", idle); end
    @(negedge clk);
    #1;
    tb_tests++; if (out_valid !== 3'b010) begin tb_fails++; $display("FAIL single_out_valid: got %b expected 010", out_valid); end
    tb_tests++; if (out_flit !== xform(f)) begin tb_fails++; $display("FAIL single_out_flit: got %h expected %h", out_flit, xform(f)); end
    @(negedge clk);
    #1;
    tb_tests++; if (out_valid !== 3'b000) begin tb_fails++; $display("FAIL single_after_valid: got %b expected 000", out_valid); end
    tb_tests++; if (idle !== 1'b1) begin tb_fails++; $display("FAIL single_after_idle: got %b expected 1", idle); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] exp_f [5];
    do_reset();
    exp_f[0] = mk(2'b01, 32'h100);
    exp_f[1] = mk(2'b00, 32'h101);
    exp_f[2] = mk(2'b00, 32'h102);
    exp_f[3] = mk(2'b00, 32'h103);
    exp_f[4] = mk(2'b10, 32'h104);
    for (int i = 0; i < 5; i++) tb_pend[0].push_back(exp_f[i]);
    run_cycles(5, 3'b000);
    tb_tests++; if (last_in_ready !== 3'b110) begin tb_fails++; $display("FAIL bp_full_in_ready: got %b expected 110", last_in_ready); end
    tb_tests++; if (tb_pend[0].size() != 1) begin tb_fails++; $display("FAIL bp_held_count: got %0d expected 1", tb_pend[0].size()); end
    tb_tests++; if (last_out_valid !== 3'b001) begin tb_fails++; $display("FAIL bp_stall_valid: got %b expected 001", last_out_valid); end
    tb_tests++; if (last_out_flit !== xform(exp_f[0])) begin tb_fails++; $display("FAIL bp_stall_flit: got %h expected %h", last_out_flit, xform(exp_f[0])); end
    run_cycles(3, 3'b000);
    tb_tests++; if (last_in_ready !== 3'b110) begin tb_fails++; $display("FAIL bp_hold_in_ready: got %b expected 110", last_in_ready); end
    tb_tests++; if (obs_vc.size() != 0) begin tb_fails++; $display("FAIL bp_no_output: got %0d expected 0", obs_vc.size()); end
    run_cycles(12, 3'b111);
    tb_tests++; if (obs_vc.size() != 5) begin tb_fails++; $display("FAIL bp_out_count: got %0d expected 5", obs_vc.size()); end
    for (int i = 0; i < 5 && i < obs_vc.size(); i++) begin
      tb_tests++;
      if (obs_vc[i] != 0 || obs_flit[i] !== xform(exp_f[i])) begin
        tb_fails++; $display("FAIL bp_order[%0d]: got vc%0d %h expected vc0 %h", i, obs_vc[i], obs_flit[i], xform(exp_f[i]));
      end
    end
    tb_tests++; if (idle !== 1'b1) begin tb_fails++; $display("FAIL bp_final_idle: got %b expected 1", idle); end
  endtask

  task automatic test_rr_packets();
    logic [FW-1:0] exp_f [$];
    int            exp_v [$];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tb_pend[0].push_back(mk((i == 0) ? 2'b01 : ((i == 2) ? 2'b10 : 2'b00), 32'h200 + i));
      tb_pend[2].push_back(mk((i == 0) ? 2'b01 : ((i == 2) ? 2'b10 : 2'b00), 32'h210 + i));
    end
    for (int i = 0; i < 3; i++) begin exp_v.push_back(0); exp_f.push_back(tb_pend[0][i]); end
    for (int i = 0; i < 3; i++) begin exp_v.push_back(2); exp_f.push_back(tb_pend[2][i]); end
    run_cycles(20, 3'b111);
    tb_tests++; if (obs_vc.size() != 6) begin tb_fails++; $display("FAIL rr1_count: got %0d expected 6", obs_vc.size()); end
    for (int i = 0; i < 6 && i < obs_vc.size(); i++) begin
      tb_tests++;
      if (obs_vc[i] != exp_v[i] || obs_flit[i] !== xform(exp_f[i])) begin
        tb_fails++; $display("FAIL rr1_order[%0d]: got vc%0d %h expected vc%0d %h", i, obs_vc[i], obs_flit[i], exp_v[i], xform(exp_f[i]));
      end
    end
    // VC2 is served last, then VC0 and VC2 both wait while VC2 is held busy
    obs_vc.delete(); obs_flit.delete(); exp_v.delete(); exp_f.delete();
    tb_pend[2].push_back(mk(2'b11, 32'h220));
    exp_v.push_back(2); exp_f.push_back(tb_pend[2][0]);
    run_cycles(1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tb_pend[0].push_back(mk((i == 0) ? 2'b01 : ((i == 2) ? 2'b10 : 2'b00), 32'h230 + i));
      tb_pend[2].push_back(mk((i == 0) ? 2'b01 : ((i == 2) ? 2'b10 : 2'b00), 32'h240 + i));
    end
    for (int i = 0; i < 3; i++) begin exp_v.push_back(0); exp_f.push_back(tb_pend[0][i]); end
    for (int i = 0; i < 3; i++) begin exp_v.push_back(2); exp_f.push_back(tb_pend[2][i]); end
    run_cycles(8, 3'b000);
    run_cycles(20, 3'b111);
    tb_tests++; if (obs_vc.size() != 7) begin tb_fails++; $display("FAIL rr2_count: got %0d expected 7", obs_vc.size()); end
    for (int i = 0; i < 7 && i < obs_vc.size(); i++) begin
      tb_tests++;
      if (obs_vc[i] != exp_v[i] || obs_flit[i] !== xform(exp_f[i])) begin
        tb_fails++; $display("FAIL rr2_order[%0d]: got vc%0d %h expected vc%0d %h", i, obs_vc[i], obs_flit[i], exp_v[i], xform(exp_f[i]));
      end
    end
  endtask

  task automatic test_multi_valid();
    logic [FW-1:0] f;
    do_reset();
    f = mk(2'b11, 32'h300);
    @(negedge clk);
    out_ready = 3'b111; in_valid = 3'b110; in_flit = f;
    #1;
    tb_tests++; if (in_ready !== 3'b010) begin tb_fails++; $display("FAIL multi_in_ready: got %b expected 010", in_ready); end
    run_cycles(6, 3'b111);
    tb_tests++; if (obs_vc.size() != 1) begin tb_fails++; $display("FAIL multi_count: got %0d expected 1", obs_vc.size()); end
    if (obs_vc.size() > 0) begin
      tb_tests++;
      if (obs_vc[0] != 1 || obs_flit[0] !== xform(f)) begin
        tb_fails++; $display("FAIL multi_flit: got vc%0d %h expected vc1 %h", obs_vc[0], obs_flit[0], xform(f));
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [FW-1:0] h;
    do_reset();
    h = mk(2'b01, 32'h400);
    tb_pend[0].push_back(h);
    tb_pend[0].push_back(mk(2'b00, 32'h401));
    tb_pend[0].push_back(mk(2'b10, 32'h402));
    run_cycles(4, 3'b000);
    run_cycles(1, 3'b111);
    tb_tests++; if (obs_vc.size() != 1 || obs_flit[0] !== xform(h)) begin tb_fails++; $display("FAIL rstmid_header: got %0d flits, first %h expected 1 flit %h", obs_vc.size(), obs_flit[0], xform(h)); end
    @(negedge clk);
    out_ready = 3'b111; in_valid = '0; in_flit = '0;
    #1;
    rst_sys_n = 1'b0;
    #1;
    tb_tests++; if (out_valid !== 3'b000) begin tb_fails++; $display("FAIL rstmid_valid: got %b expected 000", out_valid); end
    tb_tests++; if (idle !== 1'b1) begin tb_fails++; $display("FAIL rstmid_idle: got %b expected 1", idle); end
    tb_tests++; if (out_flit !== 34'h0) begin tb_fails++; $display("FAIL rstmid_flit: got %h expected 0", out_flit); end
    @(negedge clk);
    rst_sys_n = 1'b1;
    clear_logs();
    run_cycles(8, 3'b111);
    tb_tests++; if (obs_vc.size() != 0) begin tb_fails++; $display("FAIL rstmid_replay: got %0d flits expected 0", obs_vc.size()); end
    tb_tests++; if (idle !== 1'b1) begin tb_fails++; $display("FAIL rstmid_final_idle: got %b expected 1", idle); end
  endtask

`ifdef OPTIMSOC_NOC_LOOPBACK_SWAP_EN
  task automatic test_swap();
    logic [FW-1:0] hi, ho, pl, tl;
    do_reset();
    hi = {2'b01, 5'd5, 3'd1, 5'd2, 19'h01234};
    ho = {2'b01, 5'd2, 3'd1, 5'd5, 19'h01234};
    pl = {2'b00, 5'd5, 3'd1, 5'd2, 19'h05678};
    tl = {2'b10, 5'd5, 3'd1, 5'd2, 19'h09abc};
    tb_pend[1].push_back(hi);
    tb_pend[1].push_back(pl);
    tb_pend[1].push_back(tl);
    run_cycles(12, 3'b111);
    tb_tests++; if (obs_vc.size() != 3) begin tb_fails++; $display("FAIL swap_count: got %0d expected 3", obs_vc.size()); end
    if (obs_vc.size() == 3) begin
      tb_tests++; if (obs_flit[0] !== ho) begin tb_fails++; $display("FAIL swap_header: got %h expected %h", obs_flit[0], ho); end
      tb_tests++; if (obs_flit[1] !== pl) begin tb_fails++; $display("FAIL swap_payload: got %h expected %h", obs_flit[1], pl); end
      tb_tests++; if (obs_flit[2] !== tl) begin tb_fails++; $display("FAIL swap_last: got %h expected %h", obs_flit[2], tl); end
    end
  endtask
`endif

  // Queue-level model: per-VC FIFOs, one packet owner at a time, round-robin on release
  task automatic test_random();
    logic [FW-1:0]  mq [NVC][$];
    int             owner, last, own0, lo, nset;
    logic [NVC-1:0] er, eov;
    logic [FW-1:0]  ef, f;
    logic [1:0]     t;
    logic           eidle;
    do_reset();
    owner = -1;
    last  = NVC - 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < NVC; k++) begin
        in_valid[k]  = (c < 1440) && ($urandom_range(99, 0) < 35);
        out_ready[k] = (c >= 1440) || ($urandom_range(99, 0) < 75);
      end
      t = 2'($urandom_range(3, 0));
      in_flit = {t, 32'($urandom)};
      #1;
      nset = $countones(in_valid);
      lo = -1;
      for (int k = NVC - 1; k >= 0; k--) if (in_valid[k]) lo = k;
      for (int k = 0; k < NVC; k++) er[k] = (mq[k].size() < DEPTH) && (nset <= 1 || k == lo);
      eov = '0;
      if (owner >= 0 && mq[owner].size() > 0) eov[owner] = 1'b1;
      ef = (eov != '0) ? xform(mq[owner][0]) : '0;
      eidle = (owner < 0);
      for (int k = 0; k < NVC; k++) if (mq[k].size() > 0) eidle = 1'b0;
      tb_tests++; if (in_ready !== er) begin tb_fails++; $display("FAIL rand_in_ready@%0d: got %b expected %b", c, in_ready, er); end
      tb_tests++; if (out_valid !== eov) begin tb_fails++; $display("FAIL rand_out_valid@%0d: got %b expected %b", c, out_valid, eov); end
      tb_tests++; if (out_flit !== ef) begin tb_fails++; $display("FAIL rand_out_flit@%0d: got %h expected %h", c, out_flit, ef); end
      tb_tests++; if (idle !== eidle) begin tb_fails++; $display("FAIL rand_idle@%0d: got %b expected %b", c, idle, eidle); end
      own0 = owner;
      if (own0 >= 0) begin
        if (eov != '0 && out_ready[own0]) begin
          f = mq[own0].pop_front();
          if (f[FW-1]) begin
            last  = own0;
            owner = -1;
          end
        end
      end else begin
        for (int i = 1; i <= NVC; i++) begin
          if (owner < 0 && mq[(last + i) % NVC].size() > 0) owner = (last + i) % NVC;
        end
      end
      for (int k = 0; k < NVC; k++) if (in_valid[k] && er[k]) mq[k].push_back(in_flit);
    end
  endtask

  initial begin
    rst_sys_n = 1'b0;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '0;
    test_reset();
    test_single_flit();
    test_backpressure();
    test_rr_packets();
    test_multi_valid();
    test_reset_mid_packet();
`ifdef OPTIMSOC_NOC_LOOPBACK_SWAP_EN
    test_swap();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tb_tests, tb_fails);
    $finish;
  end

endmodule
